flag_update_unit: RTL

- Execute-stage block directly upstream of the 3-bit flag register.
- Turns ALU results and flag-affecting opcodes (arith, logic, SETC, CLRC) into a registered one-shot write (flag_wdata/flag_we) for the flag register.
- Keeps a small LIFO of saved flags so INT can save the flags and RTI can restore them.

---
 rtl/flag_update_unit_pkg.sv | 24 ++
 rtl/flag_update_unit_if.sv | 46 ++++
 rtl/flag_update_unit_stack.sv | 55 +++++
 rtl/flag_update_unit.sv | 113 +++++++++++
 4 files changed

// File: rtl/flag_update_unit_pkg.sv
// Shared flag bit positions, flag_op encodings and jump-condition encodings.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package flag_pkg;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_W = 3;

   // flag_op encodings; 5..7 are reserved and behave as OP_NONE
   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_ARITH = 3'd1;
   localparam logic [2:0] OP_LOGIC = 3'd2;
   localparam logic [2:0] OP_SETC  = 3'd3;
   localparam logic [2:0] OP_CLRC  = 3'd4;

   // jmp_cond encodings; the value is also the bit index of the tested flag
   localparam logic [1:0] JMP_Z      = 2'd0;
   localparam logic [1:0] JMP_N      = 2'd1;
   localparam logic [1:0] JMP_C      = 2'd2;
   localparam logic [1:0] JMP_ALWAYS = 2'd3;

endpackage

// File: rtl/flag_update_unit_if.sv
// Execute-stage bundle between the pipeline, the flag unit and the flag register.
// Latency: none (wiring only). Optional jump ports present when FLAG_JMP_CLEAR_EN is defined.
// Backpressure: none; stall/flush are carried as plain qualifiers.
interface flag_update_unit_if
   import flag_pkg::*;
#(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] alu_result;
   logic              alu_carry;
   logic [2:0]        flag_op;
   logic              in_valid;
   logic              stall;
   logic              flush;
   logic              int_save;
   logic              rti_restore;
   logic [FLAG_W-1:0] cur_flags;
   logic [FLAG_W-1:0] flag_wdata;
   logic              flag_we;
   logic              stack_full;
   logic              stack_empty;
   logic              stack_err;
`ifdef FLAG_JMP_CLEAR_EN
   logic              jmp_taken;
   logic [1:0]        jmp_cond;
`endif

   modport master (
      output alu_result, alu_carry, flag_op, in_valid, stall, flush,
      output int_save, rti_restore, cur_flags,
`ifdef FLAG_JMP_CLEAR_EN
      output jmp_taken, jmp_cond,
`endif
      input  flag_wdata, flag_we, stack_full, stack_empty, stack_err
   );

   modport slave (
      input  alu_result, alu_carry, flag_op, in_valid, stall, flush,
      input  int_save, rti_restore, cur_flags,
`ifdef FLAG_JMP_CLEAR_EN
      input  jmp_taken, jmp_cond,
`endif
      output flag_wdata, flag_we, stack_full, stack_empty, stack_err
   );

endinterface

// File: rtl/flag_update_unit_stack.sv
// LIFO of saved flag vectors for interrupt entry / RTI.
// Latency: push/pop take effect at the sampling edge; err is a registered one-cycle pulse.
// Backpressure: none; push-when-full and pop-when-empty are dropped and flagged on err.
module flag_stack
   import flag_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = FLAG_W
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] push_data,
   output logic [WIDTH-1:0] top_data,
   output logic             full,
   output logic             empty,
   output logic             err
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_sp;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             r_err;
   logic [AW:0]      w_sp_m1;
   logic             w_do_push;
   logic             w_do_pop;

   assign full      = (r_sp == (AW+1)'(DEPTH));
   assign empty     = (r_sp == '0);
   assign err       = r_err;
   assign w_sp_m1   = r_sp - (AW+1)'(1);
   assign top_data  = r_mem[w_sp_m1[AW-1:0]];
   // a simultaneous push is always dropped in favour of the pop
   assign w_do_pop  = pop & ~empty;
   assign w_do_push = push & ~pop & ~full;

   // stack pointer, storage and error pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sp  <= '0;
         r_err <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_err <= (push & pop) | (push & ~pop & full) | (pop & empty);
         if (w_do_pop) begin
            r_sp <= w_sp_m1;
         end else if (w_do_push) begin
            r_mem[r_sp[AW-1:0]] <= push_data;
            r_sp                <= r_sp + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/flag_update_unit.sv
// Decodes flag-affecting ops into a one-shot flag register write and manages INT/RTI flag save.
// Latency: inputs sampled at posedge t, flag_we/flag_wdata valid in cycle t+1. Jump flag clear with FLAG_JMP_CLEAR_EN.
// Backpressure: none; stall/flush/~in_valid simply suppress the write and any stack action.
module flag_update_unit
   import flag_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int STACK_DEPTH = 4
)(
   input  logic               clk,
   input  logic               reset,
   flag_update_unit_if.slave  bus
);
   logic              r_flag_we;
   logic [FLAG_W-1:0] r_flag_wdata;
   logic              w_accept;
   logic [FLAG_W-1:0] w_eff;
   logic [FLAG_W-1:0] w_top;
   logic              w_full;
   logic              w_empty;
   logic              w_err;
   logic              w_pop;
   logic              w_z;
   logic              w_n;
   logic              w_nxt_we;
   logic [FLAG_W-1:0] w_nxt_wd;

   assign w_accept = bus.in_valid & ~bus.stall & ~bus.flush;
   // a write issued last cycle has not reached cur_flags yet, so forward it
   assign w_eff    = r_flag_we ? r_flag_wdata : bus.cur_flags;
   assign w_z      = (bus.alu_result == '0);
   assign w_n      = bus.alu_result[DATA_W-1];
   assign w_pop    = w_accept & bus.rti_restore;

   flag_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (FLAG_W)
   ) u_stack (
      .clk       (clk),
      .reset     (reset),
      .push      (w_accept & bus.int_save),
      .pop       (w_pop),
      .push_data (w_eff),
      .top_data  (w_top),
      .full      (w_full),
      .empty     (w_empty),
      .err       (w_err)
   );

   // next write: restore beats jump clear beats the ordinary flag_op
   always_comb begin
      w_nxt_we = 1'b0;
      w_nxt_wd = r_flag_wdata;
      if (w_pop) begin
         if (!w_empty) begin
            w_nxt_we = 1'b1;
            w_nxt_wd = w_top;
         end
`ifdef FLAG_JMP_CLEAR_EN
      end else if (w_accept && bus.jmp_taken && bus.jmp_cond != JMP_ALWAYS) begin
         w_nxt_we               = 1'b1;
         w_nxt_wd               = w_eff;
         w_nxt_wd[bus.jmp_cond] = 1'b0;
`endif
      end else if (w_accept) begin
         case (bus.flag_op)
            OP_ARITH: begin
               w_nxt_we         = 1'b1;
               w_nxt_wd[FLAG_Z] = w_z;
               w_nxt_wd[FLAG_N] = w_n;
               w_nxt_wd[FLAG_C] = bus.alu_carry;
            end
            OP_LOGIC: begin
               w_nxt_we         = 1'b1;
               w_nxt_wd[FLAG_Z] = w_z;
               w_nxt_wd[FLAG_N] = w_n;
               w_nxt_wd[FLAG_C] = w_eff[FLAG_C];
            end
            OP_SETC: begin
               w_nxt_we         = 1'b1;
               w_nxt_wd         = w_eff;
               w_nxt_wd[FLAG_C] = 1'b1;
            end
            OP_CLRC: begin
               w_nxt_we         = 1'b1;
               w_nxt_wd         = w_eff;
               w_nxt_wd[FLAG_C] = 1'b0;
            end
            default: begin
               w_nxt_we = 1'b0;
            end
         endcase
      end
   end

   // registered one-shot write towards the flag register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_flag_we    <= 1'b0;
         r_flag_wdata <= '0;
      end else begin
         r_flag_we    <= w_nxt_we;
         r_flag_wdata <= w_nxt_wd;
      end
   end

   assign bus.flag_we     = r_flag_we;
   assign bus.flag_wdata  = r_flag_wdata;
   assign bus.stack_full  = w_full;
   assign bus.stack_empty = w_empty;
   assign bus.stack_err   = w_err;

endmodule
